unified_mem_arbiter: RTL and testbench

Sequences a single shared memory port between the core's instruction-fetch path and its load/store path, so one unified memory can hold both code and data. It accepts one request per cycle from each side, picks a winner, drives the memory-side request/grant/valid handshake, and returns read data with a one-cycle acknowledge pulse. It sits between the core's PC/fetch logic and its data-access logic on one side and the memory on the other, and raises `stall` so the core holds state while an access is outstanding.

---
 rtl/unified_mem_arbiter_pkg.sv | 15 +
 rtl/unified_mem_arbiter_if.sv | 44 ++++
 rtl/unified_mem_arbiter_perf.sv | 23 ++
 rtl/unified_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam logic [2:0] RTYPE_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Core-side fetch/data channels plus the shared memory port.
// master = arbiter view, slave = core + memory view.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [1:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_rtype;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic [1:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_rtype;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic              stall;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_rtype,
    input  m_gnt, m_rvalid, m_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_rtype, stall
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_rtype,
    output m_gnt, m_rvalid, m_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_rtype, stall
  );
endinterface

// File: rtl/unified_mem_arbiter_perf.sv
// Wait-cycle counters for the fetch and data channels (built under ARB_PERF_CNT_EN).
module arb_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        if_ack,
  input  logic        d_req,
  input  logic        d_ack,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_d_wait
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (if_req && !if_ack) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_req && !d_ack)   perf_d_wait  <= perf_d_wait + 32'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional ARB_PERF_CNT_EN adds perf_if_wait/perf_d_wait wait-cycle counters.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  unified_mem_arbiter_if.master  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_if_wait,
  output logic [31:0]            perf_d_wait
`endif
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_t              state;
  owner_t              owner;
  logic [STREAK_W-1:0] streak;

  logic              m_req_r;
  logic [1:0]        m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic [2:0]        m_rtype_r;
  logic              if_ack_r;
  logic              d_ack_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  logic fetch_wins;
  logic complete;

  // Data has priority unless fetch has already waited through MAX_D_STREAK data grants.
  assign fetch_wins = bus.if_req && (!bus.d_req || (streak == STREAK_MAX));

  assign complete = ((state == REQ)  && bus.m_gnt && bus.m_rvalid) ||
                    ((state == WAIT) && bus.m_rvalid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      streak     <= '0;
      m_req_r    <= 1'b0;
      m_we_r     <= '0;
      m_addr_r   <= '0;
      m_wdata_r  <= '0;
      m_rtype_r  <= '0;
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            owner     <= OWN_IF;
            m_we_r    <= WE_NONE;
            m_addr_r  <= bus.if_addr;
            m_wdata_r <= '0;
            m_rtype_r <= RTYPE_WORD;
            streak    <= '0;
            m_req_r   <= 1'b1;
            state     <= REQ;
          end else if (bus.d_req) begin
            owner     <= OWN_D;
            m_we_r    <= bus.d_we;
            m_addr_r  <= bus.d_addr;
            m_wdata_r <= bus.d_wdata;
            m_rtype_r <= bus.d_rtype;
            m_req_r   <= 1'b1;
            state     <= REQ;
            if (!bus.if_req)              streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
          end else begin
            streak <= '0;
          end
        end
        REQ: begin
          if (bus.m_gnt) begin
            m_req_r <= 1'b0;
            state   <= bus.m_rvalid ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (bus.m_rvalid) state <= RESP;
        end
        RESP: begin
          if_ack_r <= 1'b0;
          d_ack_r  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Completion is shared by the REQ fast path and WAIT; the ack lands in RESP.
      if (complete) begin
        if (owner == OWN_IF) begin
          if_rdata_r <= bus.m_rdata;
          if_ack_r   <= 1'b1;
        end else begin
          d_rdata_r <= bus.m_rdata;
          d_ack_r   <= 1'b1;
        end
      end
    end
  end

  assign bus.m_req    = m_req_r;
  assign bus.m_we     = m_we_r;
  assign bus.m_addr   = m_addr_r;
  assign bus.m_wdata  = m_wdata_r;
  assign bus.m_rtype  = m_rtype_r;
  assign bus.if_ack   = if_ack_r;
  assign bus.d_ack    = d_ack_r;
  assign bus.if_rdata = if_rdata_r;
  assign bus.d_rdata  = d_rdata_r;
  assign bus.stall    = reset & (bus.if_req | bus.d_req) & ~(if_ack_r | d_ack_r);

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .if_req       (bus.if_req),
    .if_ack       (if_ack_r),
    .d_req        (bus.d_req),
    .d_ack        (d_ack_r),
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: transaction table plus arbitration,
// starvation-guard and reset sequences.
module tb_unified_mem_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_d_wait;
`endif

  unified_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] if_rd_exp = '0;
  logic [31:0] d_rd_exp  = '0;
  logic        d_known   = 1'b1;

  typedef struct {
    owner_t      own;
    logic [31:0] addr;
    logic [1:0]  we;
    logic [31:0] wdata;
    logic [2:0]  rtype;
    int          gd;      // cycles m_gnt is withheld
    int          rd;      // cycles from m_gnt to m_rvalid (0 = same cycle)
    logic [31:0] rdata;
    logic        stray;   // m_rvalid without m_gnt during REQ
    logic [1:0]  e_we;
    logic [2:0]  e_rtype;
    int          e_ack;   // cycle of the ack pulse, counted from the IDLE request cycle
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_m_req",    32'(bus.m_req), 32'd0);
    chk("rst_m_we",     32'(bus.m_we), 32'd0);
    chk("rst_m_addr",   bus.m_addr, 32'd0);
    chk("rst_m_wdata",  bus.m_wdata, 32'd0);
    chk("rst_m_rtype",  32'(bus.m_rtype), 32'd0);
    chk("rst_if_ack",   32'(bus.if_ack), 32'd0);
    chk("rst_d_ack",    32'(bus.d_ack), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata",  bus.d_rdata, 32'd0);
    chk("rst_stall",    32'(bus.stall), 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_perf_if",  perf_if_wait, 32'd0);
    chk("rst_perf_d",   perf_d_wait, 32'd0);
`endif
  endtask

  task automatic drive_req(input vec_t v);
    if (v.own == OWN_IF) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_rtype = v.rtype;
    end
  endtask

  // Entered just after the edge that starts the IDLE cycle in which v is granted.
  task automatic do_txn(input vec_t v);
    for (int c = 0; c <= v.e_ack; c++) begin
      bus.m_gnt    = (c == 1 + v.gd);
      bus.m_rvalid = (c == 1 + v.gd + v.rd) || (v.stray && c == 1 && v.gd > 0);
      bus.m_rdata  = (c == 1 + v.gd + v.rd) ? v.rdata : 32'hBADC0FFE;
      @(negedge clk);
      chk("stall",  32'(bus.stall),  32'(c != v.e_ack));
      chk("if_ack", 32'(bus.if_ack), 32'(c == v.e_ack && v.own == OWN_IF));
      chk("d_ack",  32'(bus.d_ack),  32'(c == v.e_ack && v.own == OWN_D));
      chk("m_req",  32'(bus.m_req),  32'(c >= 1 && c <= 1 + v.gd));
      if (c >= 1 && c <= 1 + v.gd) begin
        chk("m_addr",  bus.m_addr, v.addr);
        chk("m_we",    32'(bus.m_we), 32'(v.e_we));
        chk("m_rtype", 32'(bus.m_rtype), 32'(v.e_rtype));
        if (v.own == OWN_D) chk("m_wdata", bus.m_wdata, v.wdata);
      end
      if (c == v.e_ack) begin
        if (v.own == OWN_IF) begin
          chk("if_rdata", bus.if_rdata, v.rdata);
          if (d_known) chk("d_rdata_hold", bus.d_rdata, d_rd_exp);
        end else begin
          if (v.e_we == WE_NONE) chk("d_rdata", bus.d_rdata, v.rdata);
          chk("if_rdata_hold", bus.if_rdata, if_rd_exp);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    if (v.own == OWN_IF) begin
      if_rd_exp  = v.rdata;
      bus.if_req = 1'b0;
    end else begin
      d_known   = (v.e_we == WE_NONE);
      d_rd_exp  = v.rdata;
      bus.d_req = 1'b0;
    end
  endtask

  initial begin
    vec_t vd, vi, fv, dv, rv;

    //            own     addr          we     wdata         rtype   gd rd rdata          stray e_we   e_rtype e_ack
    vecs[0] = '{OWN_IF, 32'h0000_0100, 2'b00, 32'h0,        3'b000, 0, 1, 32'h0050_0093, 1'b0, 2'b00, 3'b010, 3};
    vecs[1] = '{OWN_D,  32'h0000_0300, 2'b00, 32'h0,        3'b010, 1, 1, 32'h1234_5678, 1'b0, 2'b00, 3'b010, 4};
    vecs[2] = '{OWN_IF, 32'h0000_0104, 2'b00, 32'h0,        3'b000, 3, 2, 32'h0000_0013, 1'b1, 2'b00, 3'b010, 7};
    vecs[3] = '{OWN_D,  32'h0000_0402, 2'b10, 32'h0000_BEEF, 3'b001, 0, 0, 32'h0,        1'b0, 2'b10, 3'b001, 2};
    vecs[4] = '{OWN_D,  32'h0000_0403, 2'b00, 32'h0000_0055, 3'b100, 2, 1, 32'h0000_00A5, 1'b1, 2'b00, 3'b100, 5};
    vecs[5] = '{OWN_IF, 32'h0000_0108, 2'b00, 32'h0,        3'b000, 0, 0, 32'h0010_0073, 1'b0, 2'b00, 3'b010, 2};

    bus.if_req = 1'b1;  // stall must still read 0 while in reset
    bus.if_addr = '0;
    bus.d_req = 1'b0;  bus.d_we = '0;  bus.d_addr = '0;  bus.d_wdata = '0;  bus.d_rtype = '0;
    bus.m_gnt = 1'b0;  bus.m_rvalid = 1'b0;  bus.m_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.if_req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i]);
      do_txn(vecs[i]);
`ifdef ARB_PERF_CNT_EN
      if (i == 0) begin
        chk("perf_if_wait", perf_if_wait, 32'd3);
        chk("perf_d_wait",  perf_d_wait, 32'd0);
      end
`endif
    end

    // Simultaneous requests: store first, fetch in the IDLE right after d_ack.
    vd = '{OWN_D,  32'h0000_0200, 2'b11, 32'hDEAD_BEEF, 3'b010, 0, 1, 32'h0,        1'b0, 2'b11, 3'b010, 3};
    vi = '{OWN_IF, 32'h0000_0180, 2'b00, 32'h0,         3'b000, 0, 1, 32'h0000_0297, 1'b0, 2'b00, 3'b010, 3};
    drive_req(vd);
    drive_req(vi);
    do_txn(vd);
    do_txn(vi);

    // Starvation guard: 4 data grants, 1 fetch, then the pattern repeats.
    fv = '{OWN_IF, 32'h0000_2000, 2'b00, 32'h0, 3'b000, 0, 1, 32'h0000_1111, 1'b0, 2'b00, 3'b010, 3};
    dv = '{OWN_D,  32'h0000_1000, 2'b00, 32'h0, 3'b010, 0, 1, 32'h0000_A000, 1'b0, 2'b00, 3'b010, 3};
    drive_req(fv);
    drive_req(dv);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        do_txn(fv);
        fv.addr  = fv.addr + 32'd4;
        fv.rdata = fv.rdata + 32'd1;
        if (i < 9) drive_req(fv);
      end else begin
        do_txn(dv);
        dv.addr  = dv.addr + 32'd4;
        dv.rdata = dv.rdata + 32'd1;
        drive_req(dv);
      end
    end
    bus.d_req = 1'b0;

    // Reset while WAITing on m_rvalid.
    bus.d_req = 1'b1;  bus.d_we = WE_NONE;  bus.d_addr = 32'h500;  bus.d_rtype = RTYPE_WORD;
    @(negedge clk);
    chk("rw_stall_idle", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.m_gnt = 1'b1;
    @(negedge clk);
    chk("rw_m_req", 32'(bus.m_req), 32'd1);
    @(posedge clk);
    #1;
    bus.m_gnt = 1'b0;
    bus.if_req = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_stall_in_reset", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_rvalid = 1'b1;  // late response must not complete anything
    bus.m_rdata = 32'hBADC0FFE;
    @(negedge clk);
    chk_all_zero();
    @(posedge clk);
    #1;
    bus.m_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_if_ack_after", 32'(bus.if_ack), 32'd0);
    chk("rw_d_ack_after",  32'(bus.d_ack), 32'd0);
    chk("rw_m_req_after",  32'(bus.m_req), 32'd0);
    chk("rw_d_rdata_after", bus.d_rdata, 32'd0);
    @(posedge clk);
    #1;
    if_rd_exp = '0;
    d_rd_exp  = '0;
    d_known   = 1'b1;

    rv = vecs[0];
    rv.rdata = 32'h0000_0517;
    drive_req(rv);
    do_txn(rv);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
